btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/flappy_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/btn_conditioner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared button-conditioner state encodings and 50 MHz timing defaults
// Purpose: FSM state type and default debounce / auto-repeat periods.
// Ports: none (package).
package flappy_pkg;

    // 10 ms and 250 ms at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
    localparam int REPEAT_CYCLES_50MHZ   = 12500000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
// Purpose: bring an asynchronous level into the clk domain.
// Ports: clk (in), rst_n (in, async active-low), d (in, async), q (out, synchronized).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced push-button with single-cycle press pulse
// Purpose: synchronize a bouncing button, debounce both edges, emit one press
//          pulse per accepted press. Optional auto-repeat while held is built
//          when macro BTN_AUTOREPEAT_EN is defined.
// Ports: Clk (in), reset (in, async active-low), BtnRaw (in, async level),
//        Enable (in, pulse gate), BtnPress (out, 1-cycle pulse),
//        BtnLevel (out, debounced level).
module btn_conditioner
    import flappy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_50MHZ
) (
    input  logic Clk,
    input  logic reset,
    input  logic BtnRaw,
    input  logic Enable,
    output logic BtnPress,
    output logic BtnLevel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic       btn_s;
    btn_state_t state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic       rpt_fire;
    logic       press_next;
    logic       level_next;

    sync_2ff u_sync (
        .clk   (Clk),
        .rst_n (reset),
        .d     (BtnRaw),
        .q     (btn_s)
    );

    // State register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    next_state = DB_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s)
                    next_state = IDLE;
                else if (cnt == CNT_LAST)
                    next_state = HELD;
                else
                    cnt_next = cnt + CW'(1);
            end
            HELD: begin
                if (!btn_s) begin
                    next_state = DB_RELEASE;
                    cnt_next   = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s)
                    next_state = HELD;
                else if (cnt == CNT_LAST)
                    next_state = IDLE;
                else
                    cnt_next = cnt + CW'(1);
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt, rpt_next;
    logic          stay_held;

    // Counter only runs across HELD->HELD cycles, so it is already zero on
    // (re-)entry to HELD, including a return from a release glitch.
    always_comb begin
        stay_held = (state == HELD) && (next_state == HELD);
        rpt_fire  = stay_held && (rpt == RPT_LAST);
        rpt_next  = '0;
        if (stay_held && !rpt_fire)
            rpt_next = rpt + RW'(1);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)
            rpt <= '0;
        else
            rpt <= rpt_next;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Output logic: pulse only on the acceptance transition itself, so a
    // late Enable while HELD cannot produce a pulse.
    always_comb begin
        press_next = Enable && (((state == DB_PRESS) && (next_state == HELD)) || rpt_fire);
        level_next = (next_state == HELD) || (next_state == DB_RELEASE);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            BtnPress <= 1'b0;
            BtnLevel <= 1'b0;
        end else begin
            BtnPress <= press_next;
            BtnLevel <= level_next;
        end
    end

endmodule
